// File: rtl/reg_passthrough_store_pkg.sv
// Shared definitions for the generated memory primitives: address width and
// the index-width rule used to decode word addresses.
package reg_passthrough_store_pkg;

  localparam int ADDR_W = 32;

  // Number of address bits needed to select one of `depth` words (at least 1).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_passthrough_store_add.sv
// Portless stand-in for the `add` functional unit; one instance is placed
// per call/alloca site and carries no logic of its own.
module add;
endmodule

// File: rtl/reg_passthrough_store.sv
// Storage unit behind one HLS alloca: a single word or a small register file,
// with same-cycle write-through so stores and loads can chain within one state.
module reg_passthrough_store
  import reg_passthrough_store_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              wen
);

  localparam int IDX_W = idx_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] w_rword;
  logic [IDX_W-1:0] w_ridx;
  logic [IDX_W-1:0] w_widx;
  logic             w_rvalid;
  logic             w_wvalid;
  logic             w_unused_addr;

  // Upper address bits are intentionally ignored.
  assign w_unused_addr = ^{raddr, waddr};

  add u_add ();

  generate
    if (DEPTH == 1) begin : g_single
      assign w_ridx   = '0;
      assign w_widx   = '0;
      assign w_rvalid = 1'b1;
      assign w_wvalid = 1'b1;
      assign w_rword  = r_mem[0];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_mem[0] <= '0;
        end else if (wen) begin
          r_mem[0] <= wdata;
        end
      end
    end else begin : g_multi
      // Indices past DEPTH only occur for non-power-of-two depths.
      localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

      assign w_ridx   = raddr[IDX_W-1:0];
      assign w_widx   = waddr[IDX_W-1:0];
      assign w_rvalid = ({1'b0, w_ridx} < DEPTH_L);
      assign w_wvalid = ({1'b0, w_widx} < DEPTH_L);
      assign w_rword  = r_mem[w_ridx];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
          end
        end else if (wen && w_wvalid) begin
          r_mem[w_widx] <= wdata;
        end
      end
    end
  endgenerate

  // Forwarding only applies to a write that will actually land in storage.
  always_comb begin
    rdata = '0;
    if (rst) begin
      if (wen && w_wvalid && (w_widx == w_ridx)) begin
        rdata = wdata;
      end else if (w_rvalid) begin
        rdata = w_rword;
      end
    end
  end

endmodule

// File: tb/tb_reg_passthrough_store.sv
// Bench for reg_passthrough_store: seven instances (single word, A->B->C chain,
// 1-bit, depth 4, depth 3) checked each cycle against a word-array model.
module tb_reg_passthrough_store;

  localparam int NU = 7;

  logic        clk;
  logic        rst;
  logic [6:0]  tb_wen;
  logic [7:0]  tb_wdata [NU];
  logic [31:0] tb_waddr [NU];
  logic [31:0] tb_raddr [NU];
  logic [7:0]  rd [NU];
  logic        rd_w1;

  logic [7:0]  m_mem [NU][4];
  logic [7:0]  m_exp [NU];
  logic [7:0]  m_wd  [NU];

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit 0: W8/D1, units 1-3: chain A,B,C, unit 4: W1, unit 5: D4, unit 6: D3
  reg_passthrough_store #(.WIDTH(8), .DEPTH(1)) u_s8 (
    .clk(clk), .rst(rst), .raddr(tb_raddr[0]), .rdata(rd[0]),
    .waddr(tb_waddr[0]), .wdata(tb_wdata[0]), .wen(tb_wen[0]));
  reg_passthrough_store #(.WIDTH(8), .DEPTH(1)) u_ca (
    .clk(clk), .rst(rst), .raddr(tb_raddr[1]), .rdata(rd[1]),
    .waddr(tb_waddr[1]), .wdata(tb_wdata[1]), .wen(tb_wen[1]));
  reg_passthrough_store #(.WIDTH(8), .DEPTH(1)) u_cb (
    .clk(clk), .rst(rst), .raddr(tb_raddr[2]), .rdata(rd[2]),
    .waddr(tb_waddr[2]), .wdata(rd[1]), .wen(tb_wen[2]));
  reg_passthrough_store #(.WIDTH(8), .DEPTH(1)) u_cc (
    .clk(clk), .rst(rst), .raddr(tb_raddr[3]), .rdata(rd[3]),
    .waddr(tb_waddr[3]), .wdata(rd[2]), .wen(tb_wen[3]));
  reg_passthrough_store #(.WIDTH(1), .DEPTH(1)) u_w1 (
    .clk(clk), .rst(rst), .raddr(tb_raddr[4]), .rdata(rd_w1),
    .waddr(tb_waddr[4]), .wdata(tb_wdata[4][0]), .wen(tb_wen[4]));
  reg_passthrough_store #(.WIDTH(8), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .raddr(tb_raddr[5]), .rdata(rd[5]),
    .waddr(tb_waddr[5]), .wdata(tb_wdata[5]), .wen(tb_wen[5]));
  reg_passthrough_store #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .raddr(tb_raddr[6]), .rdata(rd[6]),
    .waddr(tb_waddr[6]), .wdata(tb_wdata[6]), .wen(tb_wen[6]));

  assign rd[4] = {7'b0, rd_w1};

  function automatic int depth_of(input int u);
    return (u == 5) ? 4 : (u == 6) ? 3 : 1;
  endfunction

  // Word slot selected by an address: address modulo the next power of two.
  function automatic int slot(input int u, input logic [31:0] a);
    int d;
    d = depth_of(u);
    if (d == 1) return 0;
    return int'(a % (32'd1 << $clog2(d)));
  endfunction

  function automatic bit in_range(input int u, input int s);
    return s < depth_of(u);
  endfunction

  // Evaluate every unit in chain order so B and C see upstream read data.
  task automatic model_eval();
    int rs;
    int ws;
    for (int u = 0; u < NU; u++) begin
      if (u == 2)      m_wd[u] = m_exp[1];
      else if (u == 3) m_wd[u] = m_exp[2];
      else if (u == 4) m_wd[u] = {7'b0, tb_wdata[u][0]};
      else             m_wd[u] = tb_wdata[u];
      rs = slot(u, tb_raddr[u]);
      ws = slot(u, tb_waddr[u]);
      if (!rst)                                             m_exp[u] = 8'h00;
      else if (tb_wen[u] && in_range(u, ws) && ws == rs)    m_exp[u] = m_wd[u];
      else if (in_range(u, rs))                             m_exp[u] = m_mem[u][rs];
      else                                                  m_exp[u] = 8'h00;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int u = 0; u < NU; u++)
        for (int k = 0; k < 4; k++) m_mem[u][k] = 8'h00;
    end else begin
      model_eval();
      for (int u = 0; u < NU; u++) begin
        if (tb_wen[u] && in_range(u, slot(u, tb_waddr[u])))
          m_mem[u][slot(u, tb_waddr[u])] = m_wd[u];
      end
    end
  end

  always @(negedge clk) begin
    model_eval();
    for (int u = 0; u < NU; u++) begin
      total++;
      if (rd[u] !== m_exp[u]) begin
        bad++;
        $display("FAIL model_u%0d t=%0t rdata=%h expected=%h", u, $time, rd[u], m_exp[u]);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s rdata=%h expected=%h", name, act, expv);
    end else begin
      $display("ok   %s rdata=%h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    tb_wen = '0;
    for (int u = 0; u < NU; u++) begin
      tb_wdata[u] = 8'h00;
      tb_waddr[u] = 32'd0;
      tb_raddr[u] = 32'd0;
      for (int k = 0; k < 4; k++) m_mem[u][k] = 8'h00;
    end
    repeat (3) step();
    chk("reset_state", rd[0], 8'h00);
    rst = 1'b1;

    // Forwarding and one-cycle storage latency
    tb_wen[0] = 1'b1; tb_wdata[0] = 8'h3C; #1;
    chk("fwd_same_cycle", rd[0], 8'h3C);
    step();
    tb_wen[0] = 1'b0; tb_wdata[0] = 8'h00; #1;
    chk("fwd_stored", rd[0], 8'h3C);

    // Reset asserted mid-cycle while a write is presented
    tb_wen[0] = 1'b1; tb_wdata[0] = 8'hA5; #2;
    rst = 1'b0; #1;
    chk("reset_immediate", rd[0], 8'h00);
    step();
    chk("reset_held_edge", rd[0], 8'h00);
    rst = 1'b1; tb_wen[0] = 1'b0; #1;
    chk("reset_release", rd[0], 8'h00);
    step();
    chk("reset_after_edge", rd[0], 8'h00);

    // Chain A -> B -> C in a single cycle
    tb_wdata[1] = 8'h42; tb_wen[3:1] = 3'b111; #1;
    chk("chain_c_same", rd[3], 8'h42);
    step();
    tb_wen[3:1] = 3'b000; tb_wdata[1] = 8'h00; #1;
    chk("chain_a_hold", rd[1], 8'h42);
    chk("chain_b_hold", rd[2], 8'h42);
    chk("chain_c_hold", rd[3], 8'h42);

    // 1-bit hold with noisy wdata
    tb_wen[4] = 1'b1; tb_wdata[4] = 8'h01;
    step();
    tb_wen[4] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tb_wdata[4] = 8'($urandom_range(0, 1)); #1;
      chk($sformatf("hold_%0d", i), rd[4], 8'h01);
      step();
    end

    // Address ignored when DEPTH == 1
    tb_wen[0] = 1'b1; tb_wdata[0] = 8'h11; tb_waddr[0] = 32'd7; tb_raddr[0] = 32'd3;
    step();
    tb_wen[0] = 1'b0; tb_wdata[0] = 8'h00; #1;
    chk("addr_ignore", rd[0], 8'h11);

    // DEPTH == 4
    tb_wen[5] = 1'b1; tb_waddr[5] = 32'd1; tb_wdata[5] = 8'hAA;
    step();
    tb_waddr[5] = 32'd2; tb_wdata[5] = 8'hBB;
    step();
    tb_wen[5] = 1'b0;
    tb_raddr[5] = 32'd1; #1; chk("d4_read1", rd[5], 8'hAA);
    tb_raddr[5] = 32'd2; #1; chk("d4_read2", rd[5], 8'hBB);
    tb_raddr[5] = 32'd0; #1; chk("d4_read0", rd[5], 8'h00);
    tb_raddr[5] = 32'h0000_0106; #1; chk("d4_upper_bits", rd[5], 8'hBB);
    tb_wen[5] = 1'b1; tb_waddr[5] = 32'd3; tb_wdata[5] = 8'hCC; tb_raddr[5] = 32'd1; #1;
    chk("d4_no_cross_fwd", rd[5], 8'hAA);
    step();
    tb_wen[5] = 1'b0; tb_raddr[5] = 32'd3; #1;
    chk("d4_read3", rd[5], 8'hCC);

    // DEPTH == 3: index 3 is out of range
    tb_wen[6] = 1'b1; tb_waddr[6] = 32'd3; tb_wdata[6] = 8'h77; tb_raddr[6] = 32'd3; #1;
    chk("d3_oor_no_fwd", rd[6], 8'h00);
    step();
    tb_waddr[6] = 32'd2; tb_wdata[6] = 8'h55;
    step();
    tb_wen[6] = 1'b0; tb_raddr[6] = 32'd3; #1;
    chk("d3_oor_read", rd[6], 8'h00);
    tb_raddr[6] = 32'd2; #1;
    chk("d3_read2", rd[6], 8'h55);
    tb_raddr[6] = 32'd7; #1;
    chk("d3_oor_alias", rd[6], 8'h00);

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
